// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: fetch state encoding,
// reset defaults and opcode constants for decode.
package riscv_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request,
// one-entry skid and IF/ID register toward decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [63:0]  skid_q, skid_d;
  logic         skid_vld_q, skid_vld_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_inst_q, id_inst_d;
  logic [31:0]  id_pc_q, id_pc_d;

  logic        accept;
  logic        load;
  logic [31:0] load_inst;
  logic [31:0] load_pc;

  assign imem_req_valid = (state_q == ST_REQ) && !reset;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    load       = 1'b0;
    load_inst  = NOP_INST;
    load_pc    = id_pc_q;

    unique case (state_q)
      ST_REQ: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (!stall) begin
            load      = 1'b1;
            load_inst = imem_rsp_data;
            load_pc   = req_pc_q;
            state_d   = ST_REQ;
          end else begin
            skid_d     = {imem_rsp_data, req_pc_q};
            skid_vld_d = 1'b1;
            state_d    = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (!stall) begin
          load       = 1'b1;
          load_inst  = skid_q[63:32];
          load_pc    = skid_q[31:0];
          skid_vld_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase

    if (!stall) begin
      id_valid_d = load;
      id_inst_d  = load ? load_inst : NOP_INST;
      id_pc_d    = load_pc;
    end

    // Redirect wins over stall and kills anything in flight.
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~32'd3;
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      id_pc_d    = id_pc_q;
      skid_vld_d = 1'b0;
      unique case (state_q)
        ST_REQ:   state_d = accept ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
        ST_FULL:  state_d = ST_REQ;
        ST_DRAIN: state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: transaction-level model of the fetch
// stream driven by a random-latency instruction memory.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .id_valid(id_valid),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h8) return 32'hFE00_0EE3;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetched_t;

  // Model: fetched-but-undelivered words, the one outstanding
  // request (possibly killed), next fetch address, decode view.
  fetched_t    ready_q[$];
  bit          outst;
  bit          killed;
  logic [31:0] fly_pc;
  logic [31:0] exp_addr;
  bit          exp_valid;
  logic [31:0] exp_inst;
  logic [31:0] exp_pc;

  // Memory side
  bit          pend;
  int          cnt;
  logic [31:0] mem_pc;

  task automatic model_step(input bit rst, rdy, stl, rdr,
                            input logic [31:0] rpc, input bit rspv,
                            input logic [31:0] rspd);
    bit acc;
    fetched_t f;
    if (rst) begin
      ready_q.delete();
      outst = 0; killed = 0;
      exp_addr = RST_PC;
      exp_valid = 0; exp_inst = NOP_INST; exp_pc = RST_PC;
      return;
    end
    acc = !outst && ready_q.size() == 0 && rdy;
    if (rspv && outst) begin
      outst = 0;
      if (!killed && !rdr) begin
        f.pc = fly_pc; f.inst = rspd;
        ready_q.push_back(f);
      end
    end
    if (acc) begin
      outst = 1; killed = 0; fly_pc = exp_addr;
      exp_addr = exp_addr + 32'd4;
    end
    if (rdr) begin
      ready_q.delete();
      if (outst) killed = 1;
      exp_addr = rpc & ~32'd3;
      exp_valid = 0; exp_inst = NOP_INST;
    end else if (!stl) begin
      if (ready_q.size() > 0) begin
        f = ready_q.pop_front();
        exp_valid = 1; exp_inst = f.inst; exp_pc = f.pc;
      end else begin
        exp_valid = 0; exp_inst = NOP_INST;
      end
    end
  endtask

  task automatic cycle(input bit rst, rdy, stl, rdr,
                       input logic [31:0] rpc, input int lat);
    bit exp_rv, dut_acc;
    logic [31:0] acc_addr;
    @(negedge clk);
    reset = rst; imem_req_ready = rdy; stall = stl;
    redirect_valid = rdr; redirect_pc = rpc;
    imem_rsp_valid = 0;
    if (!rst && pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1;
        imem_rsp_data = memw(mem_pc);
        pend = 0;
      end
    end
    #1;
    exp_rv = !rst && !outst && ready_q.size() == 0;
    check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    if (exp_rv) check("req_addr", imem_req_addr, exp_addr);
    dut_acc = imem_req_valid && rdy;
    acc_addr = imem_req_addr;
    model_step(rst, rdy, stl, rdr, rpc, imem_rsp_valid, imem_rsp_data);
    @(posedge clk);
    #1;
    if (rst) pend = 0;
    else if (dut_acc) begin
      pend = 1; cnt = lat; mem_pc = acc_addr;
    end
    check("id_valid", {31'd0, id_valid}, {31'd0, exp_valid});
    check("id_inst", id_inst, exp_inst);
    check("id_pc", id_pc, exp_pc);
    check("id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
  endtask

  initial begin
    bit rst, rdy, stl, rdr;
    logic [31:0] rpc;
    pend = 0; cnt = 0; mem_pc = '0;
    outst = 0; killed = 0; fly_pc = '0;
    exp_addr = RST_PC; exp_valid = 0; exp_inst = NOP_INST; exp_pc = RST_PC;

    cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 1);
    // 0x0 fetch, 1-cycle memory
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    // ready low three cycles at 0x4
    repeat (3) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    // 0x8 returns while stalled
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    // 0xC in flight, redirect to 0x103
    cycle(0, 1, 0, 0, 0, 3);
    cycle(0, 1, 0, 1, 32'h103, 1);
    repeat (3) cycle(0, 1, 0, 0, 0, 1);
    // redirect coincides with response under stall
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 1, 1, 32'h200, 1);
    repeat (3) cycle(0, 1, 0, 0, 0, 1);
    // PC wrap, then reset during WAIT
    cycle(0, 1, 0, 1, 32'hFFFF_FFFC, 1);
    repeat (4) cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 1, 32'hFFFF_FFFE, 1);
    cycle(0, 1, 0, 0, 0, 3);
    cycle(1, 1, 0, 0, 0, 1);
    repeat (3) cycle(0, 1, 0, 0, 0, 1);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom % 250) == 0;
      rdy = ($urandom % 4) != 0;
      stl = ($urandom % 3) == 0;
      rdr = ($urandom % 12) == 0;
      rpc = ($urandom % 2) ? $urandom
                           : (32'hFFFF_FFF0 | ($urandom & 32'hF));
      cycle(rst, rdy, stl, rdr, rpc, $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage plus IF/ID pipeline register for the RV32I core.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request and a valid response channel.
- Registers the returned instruction with its PC and presents it to decode. Decode drives imm_Gen and the control decoder from id_inst.
- Supports decode stalls (one-entry skid) and branch/jump redirects (kills in-flight fetch).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch word address, bits [1:0] always 0
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  branch/jump taken, restart fetch
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0)
- stall  in  1  decode cannot accept; hold IF/ID register
- id_valid  out  1  id_inst/id_pc hold a real instruction
- id_inst  out  32  instruction to decode; NOP when id_valid=0
- id_pc  out  32  PC of id_inst
- id_pc_plus4  out  32  id_pc + 4, for JAL/JALR link

Behaviour:
- Reset values:
  - pc = RESET_PC; state = REQ.
  - imem_req_valid = 0 during reset cycles; id_valid = 0.
  - id_inst = NOP 32'h0000_0013; id_pc = RESET_PC; id_pc_plus4 = RESET_PC+4.
  - Skid buffer empty; drop flag clear.
- Only one request may be outstanding. The memory returns exactly one response per accepted request, at least 1 cycle after acceptance. Responses outside WAIT/DRAIN are ignored.
- imem_req_valid = 1 only in state REQ with reset low; imem_req_addr = pc.
- Address stays stable while valid & !ready, except when redirect changes it.
- States:
  - REQ: on valid&ready, latch req_pc=pc, pc<=pc+4, go WAIT.
  - WAIT: on rsp_valid:
    - if !stall, load IF/ID (id_inst=rsp_data, id_pc=req_pc, id_valid=1), go REQ;
    - if stall, store {rsp_data, req_pc} in skid, go FULL.
  - FULL: when !stall, move skid into IF/ID, id_valid=1, go REQ.
  - DRAIN: waiting for a killed response. On rsp_valid, discard it, go REQ.
- IF/ID update rule:
  - when stall=1, id_* hold;
  - when stall=0 and no instruction is loaded that cycle, id_valid<=0 and id_inst<=NOP.
- Fetch latency: request accepted cycle N, response cycle N+k (k>=1) -> id_valid=1 at N+k+1 if not stalled.
- Redirect (highest priority, overrides stall, same cycle):
  - pc<=redirect_pc & ~3; id_valid<=0; id_inst<=NOP; skid cleared.
  - REQ with no accept -> stay REQ; next cycle addr = new pc.
  - REQ with accept that cycle -> DRAIN.
  - WAIT -> DRAIN; a response arriving the same cycle is discarded and the next state is REQ.
  - FULL -> REQ.
  - DRAIN -> stay DRAIN, unless rsp_valid arrives that cycle -> REQ.
- Stall has no effect on request issue in REQ. At most one instruction is ever buffered beyond IF/ID.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0, and id_pc_plus4 wraps the same way.
- Reset mid-operation (any state, any outstanding request): all state returns to reset values next edge. The bench must not return a stale response after reset; such a response is ignored, since state is REQ.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INST = 32'h0000_0013;
  - RESET_PC default;
  - fetch state enum {REQ, WAIT, FULL, DRAIN};
  - opcode localparams shared with decode/immediate generation.
- No sub-module needed. The skid is one 64-bit register plus valid bit, kept inline.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning 32'h00500093 at 0x0 -> imem_req_addr 0x0, 0x4, 0x8…; id_valid=1, id_inst=32'h00500093, id_pc=0x0, id_pc_plus4=0x4.
- imem_req_ready low for 3 cycles -> imem_req_addr held at 0x4, no pc increment, id_valid drops to 0 with id_inst=NOP.
- stall=1 while response 32'hFE000EE3 for 0x8 arrives -> id_* unchanged, state FULL, no new request. stall=0 -> id_inst=32'hFE000EE3, id_pc=0x8, then request for 0xC.
- redirect_valid=1, redirect_pc=0x103 while in WAIT for 0xC -> the 0xC response is discarded, next request addr=0x100, id_pc of the next valid instruction = 0x100.
- Redirect in the same cycle as rsp_valid in WAIT, with stall=1 -> id_valid=0, response dropped, next request to redirect target; stall does not block the redirect.
- pc=32'hFFFF_FFFC fetch then reset asserted during WAIT -> next addr is 0x0 (wrap), and after reset the first request is RESET_PC with id_valid=0.
